// File: rtl/rep7_pkg.sv
// rep7_pkg: shared constants and types for the 7-lane repetition encoder.
package rep7_pkg;

    localparam int REP_LEN = 7;

    typedef enum logic {IDLE, SEND} state_t;

    typedef logic [REP_LEN-1:0] codeword_t;

    // One-hot inversion mask; lane 7 does not exist, so it selects nothing.
    function automatic codeword_t lane_mask(input logic en, input logic [2:0] lane);
        return (en && lane != 3'd7) ? codeword_t'(1) << lane : '0;
    endfunction

endpackage

// File: rtl/rep7_bit_encode.sv
// rep7_bit_encode: replicates one data bit onto all lanes, with optional single-lane inversion.
module rep7_bit_encode
    import rep7_pkg::*;
(
    input  logic       bit_in,
    input  logic       inj_en,
    input  logic [2:0] inj_lane,
    output codeword_t  code
);

    assign code = {REP_LEN{bit_in}} ^ lane_mask(inj_en, inj_lane);

endmodule

// File: rtl/rep7_encoder_tx.sv
// rep7_encoder_tx: serialises a data word into one 7-lane repetition codeword per bit.
// Define REP7_ERR_INJ_EN to add the inj_en/inj_lane lane-inversion ports.
module rep7_encoder_tx
    import rep7_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output codeword_t         m_code,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy
`ifdef REP7_ERR_INJ_EN
    ,
    input  logic              inj_en,
    input  logic [2:0]        inj_lane
`endif
);

    localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sreg;
    logic              beat, load, cur_bit, enc_inj_en;
    logic [2:0]        enc_lane;
    codeword_t         code;

    assign busy    = state == SEND;
    assign m_valid = busy;
    assign m_last  = busy && cnt == CNT_MAX;
    assign beat    = m_valid && m_ready;
    // Accepting on the final beat lets the next word follow without a bubble.
    assign s_ready = !busy || (beat && m_last);
    assign load    = s_valid && s_ready;
    assign cur_bit = MSB_FIRST ? sreg[DATA_W-1] : sreg[0];

    always_comb begin
        state_nxt = load ? SEND : (beat && m_last) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                sreg <= s_data;
                cnt  <= '0;
            end else if (beat) begin
                sreg <= MSB_FIRST ? sreg << 1 : sreg >> 1;
                cnt  <= m_last ? '0 : cnt + CW'(1);
            end
        end
    end

`ifdef REP7_ERR_INJ_EN
    assign enc_inj_en = inj_en && m_valid;
    assign enc_lane   = inj_lane;
`else
    assign enc_inj_en = 1'b0;
    assign enc_lane   = 3'd7;
`endif

    rep7_bit_encode u_enc (
        .bit_in   (cur_bit),
        .inj_en   (enc_inj_en),
        .inj_lane (enc_lane),
        .code     (code)
    );

    assign m_code = m_valid ? code : '0;

endmodule

// File: tb/tb_rep7_encoder_tx.sv
// tb_rep7_encoder_tx: scoreboard bench for rep7_encoder_tx (MSB-first, LSB-first and 1-bit builds).
module tb_rep7_encoder_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] a_s_data;
    logic       a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_m_last, a_busy;
    logic [6:0] a_m_code;
    logic [6:0] inj_mask = 7'h00;
`ifdef REP7_ERR_INJ_EN
    logic       inj_en = 1'b0;
    logic [2:0] inj_lane = 3'd7;
`endif

    logic [7:0] b_s_data;
    logic       b_s_valid, b_s_ready, b_m_valid, b_m_last, b_busy;
    logic       b_m_ready = 1'b1;
    logic [6:0] b_m_code;

    logic       c_s_data, c_s_valid, c_s_ready, c_m_valid, c_m_last, c_busy;
    logic       c_m_ready = 1'b1;
    logic [6:0] c_m_code;

    // Scoreboard entries: {data bit, last, codeword}
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [8:0] qc[$];

    rep7_encoder_tx #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .m_code(a_m_code), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_last(a_m_last), .busy(a_busy)
`ifdef REP7_ERR_INJ_EN
        , .inj_en(inj_en), .inj_lane(inj_lane)
`endif
    );

    rep7_encoder_tx #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .m_code(b_m_code), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_last(b_m_last), .busy(b_busy)
`ifdef REP7_ERR_INJ_EN
        , .inj_en(1'b0), .inj_lane(3'd7)
`endif
    );

    rep7_encoder_tx #(.DATA_W(1), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .s_data(c_s_data), .s_valid(c_s_valid), .s_ready(c_s_ready),
        .m_code(c_m_code), .m_valid(c_m_valid), .m_ready(c_m_ready), .m_last(c_m_last), .busy(c_busy)
`ifdef REP7_ERR_INJ_EN
        , .inj_en(1'b0), .inj_lane(3'd7)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] item(input logic b, input logic last, input logic [6:0] mask);
        return {b, last, {7{b}} ^ mask};
    endfunction

    function automatic logic maj(input logic [6:0] c);
        return $countones(c) >= 4;
    endfunction

    task automatic send_a(input logic [7:0] d);
        bit ok = 0;
        for (int i = 0; i < 8; i++) qa.push_back(item(d[7-i], i == 7, inj_mask));
        a_s_data = d;
        a_s_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = a_s_ready;
        end
        if (!ok) chk("a_accept_timeout", 0, 1);
        @(posedge clk); #1;
        a_s_valid = 1'b0;
        a_s_data = 8'h3C;
    endtask

    task automatic send_b(input logic [7:0] d);
        bit ok = 0;
        for (int i = 0; i < 8; i++) qb.push_back(item(d[i], i == 7, 7'h00));
        b_s_data = d;
        b_s_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = b_s_ready;
        end
        if (!ok) chk("b_accept_timeout", 0, 1);
        @(posedge clk); #1;
        b_s_valid = 1'b0;
        b_s_data = 8'hC3;
    endtask

    task automatic send_c(input logic d);
        bit ok = 0;
        qc.push_back(item(d, 1'b1, 7'h00));
        c_s_data = d;
        c_s_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = c_s_ready;
        end
        if (!ok) chk("c_accept_timeout", 0, 1);
        @(posedge clk); #1;
        c_s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0 || a_m_valid || b_m_valid || c_m_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 500, 1);
        @(posedge clk); #1;
    endtask

    logic       a_prev_stall = 1'b0;
    logic [7:0] a_prev = '0;

    always @(negedge clk) begin : mon_a
        logic [8:0] e;
        if (rst_n && a_m_valid) begin
            if (a_prev_stall) chk("a_hold", {a_m_last, a_m_code}, a_prev);
            if (a_m_ready) begin
                if (qa.size() == 0) chk("a_unexpected_beat", {a_m_last, a_m_code}, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_code", a_m_code, e[6:0]);
                    chk("a_last", a_m_last, e[7]);
                    chk("a_majority", maj(a_m_code), e[8]);
                end
            end
        end
        a_prev_stall = rst_n && a_m_valid && !a_m_ready;
        a_prev = {a_m_last, a_m_code};
    end

    always @(negedge clk) begin : mon_b
        logic [8:0] e;
        if (rst_n && b_m_valid && b_m_ready) begin
            if (qb.size() == 0) chk("b_unexpected_beat", {b_m_last, b_m_code}, 0);
            else begin
                e = qb.pop_front();
                chk("b_code", b_m_code, e[6:0]);
                chk("b_last", b_m_last, e[7]);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        logic [8:0] e;
        if (rst_n && c_m_valid && c_m_ready) begin
            if (qc.size() == 0) chk("c_unexpected_beat", {c_m_last, c_m_code}, 0);
            else begin
                e = qc.pop_front();
                chk("c_code", c_m_code, e[6:0]);
                chk("c_last", c_m_last, e[7]);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v, r;
        bit found;
        a_s_data = 8'h00; a_s_valid = 1'b0; a_m_ready = 1'b1;
        b_s_data = 8'h00; b_s_valid = 1'b0;
        c_s_data = 1'b0;  c_s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", a_m_valid, 0);
        chk("rst_m_last", a_m_last, 0);
        chk("rst_m_code", a_m_code, 0);
        chk("rst_busy", a_busy, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_s_ready", {a_s_ready, b_s_ready, c_s_ready}, 3'b111);

        // A5 MSB first, then LSB-first 01 and a 1-bit stream in parallel
        fork
            send_a(8'hA5);
            send_b(8'h01);
            begin send_c(1'b1); send_c(1'b0); send_c(1'b1); end
        join
        drain();

        // FF with a 3-cycle stall on beat 2
        send_a(8'hFF);
        @(posedge clk); #1;
        a_m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a_m_ready = 1'b1;
        drain();

        // 80 then 01 back-to-back: 16 beats, no bubble, s_ready on each last beat
        fork
            begin send_a(8'h80); send_a(8'h01); end
            begin
                found = 0;
                for (int n = 0; n < 100 && !found; n++) begin
                    @(negedge clk);
                    found = a_m_valid;
                end
                for (int i = 0; i < 16; i++) begin
                    v[i] = a_m_valid;
                    r[i] = a_s_ready;
                    @(negedge clk);
                end
                chk("b2b_valid_run", v, 16'hFFFF);
                chk("b2b_s_ready", r, 16'h8080);
            end
        join
        drain();

        // Reset after beat 3 of F0, then 0F from bit 7
        send_a(8'hF0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_m_valid", a_m_valid, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_m_code", {a_m_last, a_m_code}, 0);
        qa.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("abort_s_ready", a_s_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_partial", a_m_valid, 0);
        send_a(8'h0F);
        drain();

`ifdef REP7_ERR_INJ_EN
        inj_en = 1'b1;
        inj_lane = 3'd3;
        inj_mask = 7'h08;
        send_a(8'hFF);
        drain();
        inj_lane = 3'd7;
        inj_mask = 7'h00;
        send_a(8'hFF);
        drain();
        inj_en = 1'b0;
`endif

        chk("final_queues_empty", qa.size() + qb.size() + qc.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
